mio_arbiter: RTL

Two-port memory arbiter for the multi-cycle CPU. It shares one synchronous instruction/data memory between the MCPU's MIO port (CPU_MIO / mem_w / Addr_out / Data_out / Data_in / MIO_ready) and a second bus master (DMA or display fetch). Each granted access is sequenced through a fixed wait-state window. Completion is signalled to the owner with a one-cycle ready pulse, so the MCPU can stall its state machine on MIO_ready.

---
 rtl/mcpu_pkg.sv | 28 ++
 rtl/rr_pick.sv | 30 +++
 rtl/mio_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mcpu_pkg.sv
// Shared types and constants for the MCPU memory arbiter: FSM states,
// owner encodings, default wait-state count and counter sizing helper.
package mcpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DEV  = 2'b10
    } owner_e;

    localparam int WAIT_CYCLES_DEFAULT = 1;

    // Wait counter width: enough bits to hold WAIT_CYCLES, never less than one.
    function automatic int cnt_width(input int wait_cycles);
        if (wait_cycles < 1) begin
            return 1;
        end else begin
            return $clog2(wait_cycles + 1);
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick between the CPU and the second master. A lone request
// wins outright; on a tie the master that was not granted last wins.
module rr_pick
    import mcpu_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dev_req,
    input  owner_e last_grant,
    output owner_e grant
);

    // Combinational grant decision for the current IDLE cycle.
    always_comb begin
        grant = OWN_NONE;
        if (cpu_req && dev_req) begin
            if (last_grant == OWN_CPU) begin
                grant = OWN_DEV;
            end else begin
                grant = OWN_CPU;
            end
        end else if (cpu_req) begin
            grant = OWN_CPU;
        end else if (dev_req) begin
            grant = OWN_DEV;
        end else begin
            grant = OWN_NONE;
        end
    end

endmodule

// File: rtl/mio_arbiter.sv
// Two-port memory arbiter: shares one synchronous memory between the MCPU
// MIO port and a second bus master. Each grant runs a fixed wait-state
// window (ACCESS) followed by a one-cycle ready pulse to the owner (DONE).
module mio_arbiter
    import mcpu_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,

    input  logic          dev_req,
    input  logic          dev_we,
    input  logic [AW-1:0] dev_addr,
    input  logic [DW-1:0] dev_wdata,
    output logic [DW-1:0] dev_rdata,
    output logic          dev_ready,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [1:0]    owner
);

    localparam int CW = cnt_width(WAIT_CYCLES);

    state_e        state_r;
    owner_e        owner_r;
    owner_e        last_grant_r;
    owner_e        grant_s;
    logic [CW-1:0] cnt_r;

    rr_pick u_rr_pick (
        .cpu_req    (cpu_req),
        .dev_req    (dev_req),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    assign owner = owner_r;

    // Arbitration FSM; every output is a register so the memory and both
    // masters see glitch-free, edge-aligned control.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            owner_r      <= OWN_NONE;
            last_grant_r <= OWN_DEV;
            cnt_r        <= {CW{1'b0}};
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= {AW{1'b0}};
            mem_wdata    <= {DW{1'b0}};
            cpu_rdata    <= {DW{1'b0}};
            dev_rdata    <= {DW{1'b0}};
            cpu_ready    <= 1'b0;
            dev_ready    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    dev_ready <= 1'b0;
                    if (grant_s == OWN_CPU) begin
                        owner_r   <= OWN_CPU;
                        mem_en    <= 1'b1;
                        mem_we    <= cpu_we;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        cnt_r     <= CW'(WAIT_CYCLES);
                        state_r   <= ACCESS;
                    end else if (grant_s == OWN_DEV) begin
                        owner_r   <= OWN_DEV;
                        mem_en    <= 1'b1;
                        mem_we    <= dev_we;
                        mem_addr  <= dev_addr;
                        mem_wdata <= dev_wdata;
                        cnt_r     <= CW'(WAIT_CYCLES);
                        state_r   <= ACCESS;
                    end else begin
                        state_r   <= IDLE;
                    end
                end

                ACCESS: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        // Last wait state: read data is valid now.
                        mem_en  <= 1'b0;
                        mem_we  <= 1'b0;
                        state_r <= DONE;
                        if (owner_r == OWN_CPU) begin
                            cpu_ready <= 1'b1;
                            if (!mem_we) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end else begin
                            dev_ready <= 1'b1;
                            if (!mem_we) begin
                                dev_rdata <= mem_rdata;
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end

                DONE: begin
                    cpu_ready    <= 1'b0;
                    dev_ready    <= 1'b0;
                    last_grant_r <= owner_r;
                    owner_r      <= OWN_NONE;
                    state_r      <= IDLE;
                end

                default: begin
                    // Unreachable encoding: drop any access and fall back to IDLE.
                    cpu_ready <= 1'b0;
                    dev_ready <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    owner_r   <= OWN_NONE;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule
